// File: rtl/sqrt_arbiter_if.sv
// Requester, response and square-root core signals shared between sqrt_arbiter and its environment.
// Signal suffixes are named from the arbiter's point of view.
`timescale 1ns/1ps
interface sqrt_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    localparam int GW = $clog2(N_REQ);

    logic [N_REQ*DW-1:0] req_dt_i;
    logic [N_REQ-1:0]    req_valid_i;
    logic [N_REQ-1:0]    req_ready_o;
    logic [DW-1:0]       rsp_dt_o;
    logic                rsp_err_o;
    logic [N_REQ-1:0]    rsp_valid_o;
    logic [N_REQ-1:0]    rsp_ready_i;
    logic                sq_enb_o;
    logic [DW-1:0]       sq_dt_o;
    logic                sq_valid_o;
    logic                sq_ready_i;
    logic [DW-1:0]       sq_dt_i;
    logic                sq_valid_i;
    logic                busy_o;
    logic [GW-1:0]       grant_o;

    modport slave (
        input  req_dt_i, req_valid_i, rsp_ready_i, sq_ready_i, sq_dt_i, sq_valid_i,
        output req_ready_o, rsp_dt_o, rsp_err_o, rsp_valid_o, sq_enb_o, sq_dt_o,
               sq_valid_o, busy_o, grant_o
    );

    modport master (
        output req_dt_i, req_valid_i, rsp_ready_i, sq_ready_i, sq_dt_i, sq_valid_i,
        input  req_ready_o, rsp_dt_o, rsp_err_o, rsp_valid_o, sq_enb_o, sq_dt_o,
               sq_valid_o, busy_o, grant_o
    );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter that shares one iterative square-root core among N_REQ requesters,
// with a watchdog that aborts an operation the core never answers.
`timescale 1ns/1ps
module sqrt_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    sqrt_arbiter_if.slave bus
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = 9;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    ptr_q, ptr_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [DW-1:0]    sq_dt_q, sq_dt_d;
    logic             sq_valid_q, sq_valid_d;
    logic             sq_enb_q, sq_enb_d;
    logic [DW-1:0]    rsp_dt_q, rsp_dt_d;
    logic             rsp_err_q, rsp_err_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             found;
    logic [GW-1:0]    pick;
    logic [GW-1:0]    idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = GW'((int'(ptr_q) + i) % N_REQ);
            if (!found && bus.req_valid_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // The operand transfer completes in the same IDLE cycle it is granted.
    always_comb begin
        bus.req_ready_o = '0;
        if (state_q == IDLE && found && rstn_i) begin
            bus.req_ready_o[pick] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        sq_dt_d     = sq_dt_q;
        sq_valid_d  = sq_valid_q;
        sq_enb_d    = sq_enb_q;
        rsp_dt_d    = rsp_dt_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d    = pick;
                    sq_dt_d    = bus.req_dt_i[int'(pick)*DW +: DW];
                    sq_valid_d = 1'b1;
                    sq_enb_d   = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.sq_ready_i) begin
                    sq_valid_d = 1'b0;
                    sq_dt_d    = '0;
                    cnt_d      = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // WAIT spans at most TIMEOUT+1 cycles; a result in the last one still wins.
                if (bus.sq_valid_i || cnt_q == CW'(TIMEOUT)) begin
                    rsp_dt_d             = bus.sq_valid_i ? bus.sq_dt_i : '1;
                    rsp_err_d            = !bus.sq_valid_i;
                    rsp_valid_d          = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    sq_enb_d             = 1'b0;
                    state_d              = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i[grant_q]) begin
                    rsp_valid_d = '0;
                    rsp_dt_d    = '0;
                    rsp_err_d   = 1'b0;
                    busy_d      = 1'b0;
                    ptr_d       = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            sq_dt_q     <= '0;
            sq_valid_q  <= 1'b0;
            sq_enb_q    <= 1'b0;
            rsp_dt_q    <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            sq_dt_q     <= sq_dt_d;
            sq_valid_q  <= sq_valid_d;
            sq_enb_q    <= sq_enb_d;
            rsp_dt_q    <= rsp_dt_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.sq_dt_o     = sq_dt_q;
    assign bus.sq_valid_o  = sq_valid_q;
    assign bus.sq_enb_o    = sq_enb_q;
    assign bus.rsp_dt_o    = rsp_dt_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.grant_o     = grant_q;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter: directed vector table, randomized transactions
// against a round-robin reference model, and a mid-operation reset sequence.
`timescale 1ns/1ps
module tb_sqrt_arbiter;
    localparam int N_REQ   = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 64;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sqrt_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

    sqrt_arbiter #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int    vectors     = 0;
    int    miscompares = 0;
    int    model_ptr   = 0;
    string cur_tag     = "init";

    // Behavioural core: stalls sq_ready_i for core_stall cycles, then answers
    // core_lat cycles into WAIT (never if core_lat < 0).
    int core_lat   = 0;
    int core_stall = 0;
    bit core_flush = 0;
    bit c_accepted = 0;
    bit c_waiting  = 0;
    int c_wcnt     = 0;
    int c_stallcnt = 0;
    int c_op       = 0;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] ops;
        int          lat;
        int          stall;
        int          hold;
        int          grant;
        logic [7:0]  dt;
        bit          err;
    } vec_t;

    vec_t vecs[15];

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int model_grant(input logic [3:0] mask);
        for (int i = 0; i < N_REQ; i++) begin
            if (mask[(model_ptr + i) % N_REQ]) return (model_ptr + i) % N_REQ;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s/%s: got %0h, expected %0h", cur_tag, name, actual, expected);
        end
    endtask

    initial begin
        bus.sq_ready_i = 1'b0;
        bus.sq_valid_i = 1'b0;
        bus.sq_dt_i    = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.sq_valid_i = 1'b0;
            bus.sq_dt_i    = '0;
            if (core_flush) begin
                core_flush     = 0;
                c_waiting      = 0;
                c_accepted     = 0;
                c_stallcnt     = 0;
                bus.sq_ready_i = 1'b0;
            end
            if (c_accepted) begin
                c_accepted     = 0;
                c_waiting      = 1;
                c_wcnt         = 0;
                bus.sq_ready_i = 1'b0;
            end
            if (c_waiting) begin
                if (c_wcnt == core_lat) begin
                    bus.sq_valid_i = 1'b1;
                    bus.sq_dt_i    = 8'(isqrt(c_op));
                    c_waiting      = 0;
                end
                c_wcnt++;
            end else if (bus.sq_valid_o) begin
                if (c_stallcnt < core_stall) begin
                    c_stallcnt++;
                    bus.sq_ready_i = 1'b0;
                end else begin
                    c_stallcnt     = 0;
                    c_op           = int'(bus.sq_dt_o);
                    c_accepted     = 1;
                    bus.sq_ready_i = 1'b1;
                end
            end
        end
    end

    // Runs one full operation starting in an IDLE cycle (posedge + 2).
    task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] ops, input int lat,
                                 input int stall, input int hold, input int exp_grant,
                                 input logic [7:0] exp_dt, input bit exp_err);
        int         exp_n;
        logic [3:0] oh;
        logic [7:0] op;
        oh    = 4'(1 << exp_grant);
        op    = ops[exp_grant*8 +: 8];
        exp_n = (lat >= 0 && lat <= TIMEOUT) ? lat + stall + 3 : stall + TIMEOUT + 3;
        core_lat   = lat;
        core_stall = stall;
        core_flush = 1;
        bus.req_valid_i = mask;
        bus.req_dt_i    = ops;
        bus.rsp_ready_i = '0;
        #1;
        checkOutput("idle_busy", 32'(bus.busy_o), 0);
        checkOutput("req_ready", 32'(bus.req_ready_o), 32'(oh));
        for (int n = 1; n < exp_n; n++) begin
            @(posedge clk);
            #1;
            bus.req_valid_i = '1;
            bus.req_dt_i    = $urandom;
            bus.rsp_ready_i = '1;
            #1;
            checkOutput("busy_ready", 32'(bus.req_ready_o), 0);
            checkOutput("busy", 32'(bus.busy_o), 1);
            checkOutput("grant", 32'(bus.grant_o), 32'(exp_grant));
            checkOutput("sq_enb", 32'(bus.sq_enb_o), 1);
            checkOutput("rsp_valid_early", 32'(bus.rsp_valid_o), 0);
            checkOutput("rsp_dt_idle", 32'(bus.rsp_dt_o), 0);
            if (n <= stall + 1) begin
                checkOutput("sq_valid", 32'(bus.sq_valid_o), 1);
                checkOutput("sq_dt", 32'(bus.sq_dt_o), 32'(op));
            end else begin
                checkOutput("sq_valid_wait", 32'(bus.sq_valid_o), 0);
                checkOutput("sq_dt_wait", 32'(bus.sq_dt_o), 0);
            end
        end
        for (int h = 0; h <= hold; h++) begin
            @(posedge clk);
            #1;
            bus.rsp_ready_i = (h == hold) ? oh : ~oh;
            #1;
            checkOutput("rsp_valid", 32'(bus.rsp_valid_o), 32'(oh));
            checkOutput("rsp_dt", 32'(bus.rsp_dt_o), 32'(exp_dt));
            checkOutput("rsp_err", 32'(bus.rsp_err_o), 32'(exp_err));
            checkOutput("resp_sq_enb", 32'(bus.sq_enb_o), 0);
            checkOutput("resp_sq_valid", 32'(bus.sq_valid_o), 0);
            checkOutput("resp_busy", 32'(bus.busy_o), 1);
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = '0;
        bus.req_dt_i    = '0;
        bus.rsp_ready_i = '0;
        #1;
        checkOutput("done_busy", 32'(bus.busy_o), 0);
        checkOutput("done_rsp_valid", 32'(bus.rsp_valid_o), 0);
        checkOutput("done_rsp_dt", 32'(bus.rsp_dt_o), 0);
        checkOutput("done_rsp_err", 32'(bus.rsp_err_o), 0);
        checkOutput("done_grant", 32'(bus.grant_o), 32'(exp_grant));
        model_ptr = (exp_grant + 1) % N_REQ;
    endtask

    task automatic checkAllZero();
        checkOutput("rst_req_ready", 32'(bus.req_ready_o), 0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
        checkOutput("rst_rsp_dt", 32'(bus.rsp_dt_o), 0);
        checkOutput("rst_rsp_err", 32'(bus.rsp_err_o), 0);
        checkOutput("rst_sq_valid", 32'(bus.sq_valid_o), 0);
        checkOutput("rst_sq_dt", 32'(bus.sq_dt_o), 0);
        checkOutput("rst_sq_enb", 32'(bus.sq_enb_o), 0);
        checkOutput("rst_busy", 32'(bus.busy_o), 0);
        checkOutput("rst_grant", 32'(bus.grant_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  mask;
        logic [31:0] ops;
        int          lat, stall, hold, g, r;
        logic [7:0]  exp_dt;
        bit          exp_err;

        vecs[0]  = '{4'hF, 32'hFF510100, 2,  0, 0, 0, 8'd0,   1'b0};
        vecs[1]  = '{4'hF, 32'hFF510100, 3,  0, 0, 1, 8'd1,   1'b0};
        vecs[2]  = '{4'hF, 32'hFF510100, 1,  0, 0, 2, 8'd9,   1'b0};
        vecs[3]  = '{4'hF, 32'hFF510100, 0,  0, 0, 3, 8'd15,  1'b0};
        vecs[4]  = '{4'h2, 32'h00001000, 5,  0, 0, 1, 8'd4,   1'b0};
        vecs[5]  = '{4'h4, 32'h00640000, 4,  0, 0, 2, 8'd10,  1'b0};
        vecs[6]  = '{4'hA, 32'hC8003100, 2,  0, 0, 3, 8'd14,  1'b0};
        vecs[7]  = '{4'h2, 32'h00003100, 3,  0, 0, 1, 8'd7,   1'b0};
        vecs[8]  = '{4'h9, 32'h32000002, 0,  0, 0, 3, 8'd7,   1'b0};
        vecs[9]  = '{4'h9, 32'h32000002, 1,  0, 0, 0, 8'd1,   1'b0};
        vecs[10] = '{4'h4, 32'h00900000, 2,  3, 0, 2, 8'd12,  1'b0};
        vecs[11] = '{4'h1, 32'h00000009, 1,  0, 5, 0, 8'd3,   1'b0};
        vecs[12] = '{4'h2, 32'h00001E00, 65, 0, 3, 1, 8'hFF,  1'b1};
        vecs[13] = '{4'h4, 32'h00400000, 64, 0, 0, 2, 8'd8,   1'b0};
        vecs[14] = '{4'h8, 32'h01000000, -1, 0, 0, 3, 8'hFF,  1'b1};

        cur_tag = "reset";
        rstn            = 1'b0;
        bus.req_valid_i = '1;
        bus.req_dt_i    = 32'hDEADBEEF;
        bus.rsp_ready_i = '0;
        repeat (3) @(posedge clk);
        #2;
        checkAllZero();
        @(posedge clk);
        #1;
        rstn            = 1'b1;
        bus.req_valid_i = '0;
        #1;
        checkAllZero();

        for (int i = 0; i < 15; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].mask, vecs[i].ops, vecs[i].lat, vecs[i].stall, vecs[i].hold,
                          vecs[i].grant, vecs[i].dt, vecs[i].err);
        end

        for (int i = 0; i < 24; i++) begin
            cur_tag = $sformatf("rand%0d", i);
            mask    = 4'($urandom_range(1, 15));
            ops     = $urandom;
            r       = $urandom_range(0, 9);
            lat     = (r == 0) ? -1 : ((r == 1) ? TIMEOUT : $urandom_range(0, 6));
            stall   = $urandom_range(0, 2);
            hold    = $urandom_range(0, 3);
            g       = model_grant(mask);
            exp_err = (lat < 0 || lat > TIMEOUT);
            exp_dt  = exp_err ? 8'hFF : 8'(isqrt(int'(ops[g*8 +: 8])));
            applyStimulus(mask, ops, lat, stall, hold, g, exp_dt, exp_err);
        end

        cur_tag = "midreset_prep";
        g = model_grant(4'h4);
        applyStimulus(4'h4, 32'h00190000, 1, 0, 0, g, 8'd5, 1'b0);

        cur_tag = "midreset";
        core_lat        = 10;
        core_stall      = 0;
        core_flush      = 1;
        bus.req_valid_i = 4'h1;
        bus.req_dt_i    = 32'h00000019;
        #1;
        checkOutput("accept", 32'(bus.req_ready_o), 32'h1);
        repeat (4) begin
            @(posedge clk);
            #1;
            bus.req_valid_i = '0;
            bus.req_dt_i    = '0;
        end
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        checkAllZero();
        model_ptr = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #2;
            checkOutput("late_pulse_rsp", 32'(bus.rsp_valid_o), 0);
            checkOutput("late_pulse_busy", 32'(bus.busy_o), 0);
        end
        cur_tag = "after_reset_a";
        applyStimulus(4'h9, 32'h40000024, 2, 0, 0, model_grant(4'h9), 8'd6, 1'b0);
        cur_tag = "after_reset_b";
        applyStimulus(4'h8, 32'h40000024, 2, 0, 0, model_grant(4'h8), 8'd8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
